hv_cmd_uart_tx: RTL and testbench
=================================

// Module: hv_cmd_uart_tx
// PURPOSE
//   Consumes the 8-bit command bytes produced by the HV command-preparation stage (In_Cmd/In_En strobes) and
//   serialises them as 8N1 (or 8N2) UART frames to the HV power-supply module. Sits directly downstream of
//   the HV command builder. A small FIFO absorbs the fast 12-byte config / 8-byte HON/HOF bursts while the line runs at baud rate.
// PARAMETERS
//   CLK_DIV     4167  Clk_In cycles per UART bit (40 MHz / 9600 Bd); legal >= 2
//   FIFO_AW     4     FIFO address width; depth DEPTH = 2**FIFO_AW = 16 bytes
//   STOP_BITS   1     number of stop bits, 1 or 2
// PORTS
//   Clk_In          in   1        system clock
//   Rst_N           in   1        asynchronous, active-low reset
//   In_Cmd          in   8        command byte, [8:1], bit 1 = LSB
//   In_En           in   1        one-cycle write strobe for In_Cmd
//   Clr_Overflow    in   1        synchronous clear of Out_Overflow
//   Out_Tx          out  1        UART serial line, idle high
//   Out_Busy        out  1        1 while FIFO non-empty or a frame is in progress
//   Out_Tx_Done     out  1        one-cycle pulse in the last cycle of each frame's final stop bit
//   Out_Overflow    out  1        sticky: a byte was dropped on a full FIFO
//   Out_Fifo_Count  out  FIFO_AW+1 bytes currently held in FIFO (0..DEPTH)
// BEHAVIOUR
//   Reset (async, Rst_N=0): Out_Tx=1, Out_Busy=0, Out_Tx_Done=0, Out_Overflow=0, Out_Fifo_Count=0,
//     FIFO pointers 0, FSM IDLE, baud/bit counters 0. Reset mid-frame aborts the frame; the line goes high immediately.
//   FIFO write: In_En=1 and count<DEPTH -> In_Cmd stored at the next edge. In_En=1 and count==DEPTH -> byte
//     dropped, Out_Overflow set, regardless of a pop in the same cycle. Simultaneous push+pop with count<DEPTH:
//     count unchanged, both take effect. Pointers wrap modulo DEPTH; count is a separate FIFO_AW+1-bit register.
//   Out_Overflow: set has priority over Clr_Overflow in the same cycle.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE: Out_Tx=1. If count>0: pop the head byte into the shift register, clear counters, go to START.
//     START: Out_Tx=0 for CLK_DIV cycles, then go to DATA.
//     DATA: Out_Tx=shift[1] (LSB first). Every CLK_DIV cycles shift right by 1 and advance the bit counter 0..7.
//       After bit 7 completes, go to STOP.
//     STOP: Out_Tx=1 for STOP_BITS*CLK_DIV cycles. In the final cycle: pulse Out_Tx_Done. If count>0, pop and go
//       directly to START (no idle gap between frames); otherwise go to IDLE.
//   Out_Tx is registered. Latency: In_En at edge N into an empty FIFO with the FSM in IDLE -> byte in FIFO after
//     edge N+1 -> popped at edge N+2 -> Out_Tx low from edge N+2.
//   Frame length: (9+STOP_BITS)*CLK_DIV cycles exactly. Bursts are sent back-to-back with no extra clocks.
//   Out_Busy = (state!=IDLE) | (count!=0), combinational from registers.
//   Baud counter width is ceil(log2(CLK_DIV)) bits. It counts 0..CLK_DIV-1 and rolls over at each bit boundary.
//   Bytes are transmitted strictly in write order. In_En when the FSM is idle is accepted normally; no special case.
// TESTING (bench with CLK_DIV=4 unless stated)
//   1 Single byte 0x02 on In_En at edge 0 -> Out_Tx low during edges 2..5, then bits 0,1,0,0,0,0,0,0
//     (4 clk each), then high 4 clk. Out_Tx_Done pulses at cycle 41. Out_Busy falls after it.
//   2 12-byte config burst 02 xx.. 03 cc cc 0D at one byte per 2 clk -> 12 contiguous frames of 40 clk (480 clk
//     total). Decoded bytes match input order. Out_Overflow stays 0. Max Out_Fifo_Count = 11.
//   3 18 bytes on 18 consecutive cycles from idle -> first byte popped, 16 buffered, 18th dropped, Out_Overflow=1.
//     17 frames are sent. Clr_Overflow pulse -> Out_Overflow=0. Clr and overflow in the same cycle -> stays 1.
//   4 Rst_N low for 1 clk during DATA bit 3 of the 2nd of 3 queued bytes -> Out_Tx=1 asynchronously, count=0.
//     No further frames. The next written byte is sent normally.
//   5 STOP_BITS=2, bytes 0xFF then 0x00 -> frames of 44 clk each, stop high for 8 clk, LSB-first bits correct.
//   6 HON sequence 02 48 4F 4E 03 45 41 0D with CLK_DIV=4167 -> UART-model decode at 9600 Bd matches exactly.

Source files
------------

// File: rtl/hv_cmd_uart_tx.sv
// 8N1/8N2 UART transmitter for HV supply command bytes, with a small FIFO that
// absorbs command bursts while the line runs at baud rate.
module hv_cmd_uart_tx #(
  parameter int unsigned CLK_DIV   = 4167,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic               Clk_In,
  input  logic               Rst_N,
  input  logic [7:0]         In_Cmd,
  input  logic               In_En,
  input  logic               Clr_Overflow,
  output logic               Out_Tx,
  output logic               Out_Busy,
  output logic               Out_Tx_Done,
  output logic               Out_Overflow,
  output logic [FIFO_AW:0]   Out_Fifo_Count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned BW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  state_t             state, state_d;
  logic [7:0]         shift, shift_d;
  logic [BW-1:0]      baud, baud_d;
  logic [2:0]         bit_cnt, bit_d;
  logic               tx_q, tx_d;
  logic               pop, push, full, baud_end;

  assign full     = (count == DEPTH_C);
  assign push     = In_En & ~full;
  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge Clk_In) begin
    if (push) mem[wr_ptr] <= In_Cmd;
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      Out_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (In_En && full)     Out_Overflow <= 1'b1;
      else if (Clr_Overflow) Out_Overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state   <= IDLE;
      shift   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    shift_d = shift;
    baud_d  = baud;
    bit_d   = bit_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_cnt == STOP_LAST) begin
            // Chain straight into the next frame so bursts leave no idle gap
            bit_d = '0;
            if (count != '0) begin
              pop     = 1'b1;
              shift_d = mem[rd_ptr];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
    endcase

    // Line level is registered from the next state so it changes with the state
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign Out_Tx         = tx_q;
  assign Out_Busy       = (state != IDLE) | (count != '0);
  assign Out_Tx_Done    = (state == STOP) & baud_end & (bit_cnt == STOP_LAST);
  assign Out_Fifo_Count = count;

endmodule

// File: tb/tb_hv_cmd_uart_tx.sv
// Randomized bench for hv_cmd_uart_tx: a frame-timing reference model predicts
// line level, busy, done, overflow and FIFO count every cycle.
module tb_hv_cmd_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int FRAME2  = 11 * CLK_DIV;

  logic       Clk_In = 1'b0;
  logic       Rst_N  = 1'b0;
  logic [7:0] In_Cmd = '0;
  logic       In_En  = 1'b0;
  logic       Clr_Overflow = 1'b0;
  logic       Out_Tx, Out_Busy, Out_Tx_Done, Out_Overflow;
  logic [4:0] Out_Fifo_Count;

  logic [7:0] in_cmd_2 = '0;
  logic       in_en_2  = 1'b0;
  logic       clr_2    = 1'b0;
  logic       tx_2, busy_2, done_2, ovf_2;
  logic [4:0] cnt_2;

  hv_cmd_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(4), .STOP_BITS(1)) dut (
    .Clk_In(Clk_In), .Rst_N(Rst_N), .In_Cmd(In_Cmd), .In_En(In_En),
    .Clr_Overflow(Clr_Overflow), .Out_Tx(Out_Tx), .Out_Busy(Out_Busy),
    .Out_Tx_Done(Out_Tx_Done), .Out_Overflow(Out_Overflow),
    .Out_Fifo_Count(Out_Fifo_Count)
  );

  hv_cmd_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(4), .STOP_BITS(2)) dut2 (
    .Clk_In(Clk_In), .Rst_N(Rst_N), .In_Cmd(in_cmd_2), .In_En(in_en_2),
    .Clr_Overflow(clr_2), .Out_Tx(tx_2), .Out_Busy(busy_2),
    .Out_Tx_Done(done_2), .Out_Overflow(ovf_2), .Out_Fifo_Count(cnt_2)
  );

  always #5 Clk_In = ~Clk_In;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Expected line level at cycle t of a frame starting at edge s
  function automatic logic tx_at(input int s, input logic [7:0] b, input int t);
    int k;
    k = (t - s) / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Reference model: line is free at free_at; a queued byte starts at the
  // first edge where it is already held and the line is free.
  int         edge_n = 0;
  logic [7:0] mq[$];
  int         free_at = 0;
  bit         fv = 0;
  int         fs = 0;
  logic [7:0] fb = '0;
  bit         m_ovf = 0;
  int         m_frames = 0;
  bit         chk_en = 0;

  initial forever begin
    int  cb;
    bit  was_full;
    @(posedge Clk_In);
    edge_n++;
    if (!Rst_N) begin
      mq.delete();
      free_at = 0;
      fv      = 0;
      m_ovf   = 0;
    end else begin
      cb       = mq.size();
      was_full = (cb == DEPTH);
      if (cb > 0 && edge_n >= free_at) begin
        fb      = mq.pop_front();
        fs      = edge_n;
        fv      = 1;
        free_at = edge_n + FRAME;
        m_frames++;
      end
      if (In_En && was_full)  m_ovf = 1;
      else if (Clr_Overflow)  m_ovf = 0;
      if (In_En && !was_full) mq.push_back(In_Cmd);
    end
  end

  initial forever begin
    logic e_tx;
    @(negedge Clk_In);
    if (chk_en) begin
      e_tx = (fv && edge_n < fs + FRAME) ? tx_at(fs, fb, edge_n) : 1'b1;
      check_val("tx",   Out_Tx,         e_tx);
      check_val("busy", Out_Busy,       (mq.size() != 0) || (fv && edge_n < free_at));
      check_val("done", Out_Tx_Done,    fv && (edge_n == fs + FRAME - 1));
      check_val("ovf",  Out_Overflow,   m_ovf);
      check_val("cnt",  Out_Fifo_Count, mq.size());
    end
  end

  task automatic send(input logic [7:0] b);
    In_Cmd = b;
    In_En  = 1'b1;
    @(posedge Clk_In); #1;
    In_En  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk_In); #1; end
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && Out_Busy; i++) begin @(posedge Clk_In); #1; end
    check_val("idle_wait", Out_Busy, 0);
  endtask

  initial begin
    logic [7:0] cfg [12];
    int         maxc, f0, e0, s1, s2, ndone;
    logic       e2;

    repeat (3) @(posedge Clk_In);
    #1;
    check_val("rst_tx",   Out_Tx, 1);
    check_val("rst_busy", Out_Busy, 0);
    check_val("rst_cnt",  Out_Fifo_Count, 0);
    Rst_N  = 1'b1;
    chk_en = 1;
    idle(2);

    // single byte
    send(8'h02);
    idle(50);

    // 12-byte config burst, one byte every 2 clk
    cfg[0] = 8'h02;
    for (int i = 1; i < 9; i++) cfg[i] = 8'($urandom);
    cfg[9] = 8'h03; cfg[10] = 8'($urandom); cfg[11] = 8'h0D;
    maxc = 0;
    for (int i = 0; i < 12; i++) begin
      send(cfg[i]);
      if (int'(Out_Fifo_Count) > maxc) maxc = Out_Fifo_Count;
      idle(1);
    end
    check_val("cfg_maxcnt", maxc, 11);
    wait_idle(1000);
    check_val("cfg_ovf", Out_Overflow, 0);

    // 18 back-to-back bytes: one popped, 16 buffered, last dropped
    for (int i = 0; i < 18; i++) send(8'($urandom));
    check_val("burst_ovf", Out_Overflow, 1);
    check_val("burst_cnt", Out_Fifo_Count, 16);
    Clr_Overflow = 1'b1; idle(1); Clr_Overflow = 1'b0;
    check_val("clr_ovf", Out_Overflow, 0);
    Clr_Overflow = 1'b1; send(8'hAA); Clr_Overflow = 1'b0;
    check_val("set_over_clr", Out_Overflow, 1);
    Clr_Overflow = 1'b1; idle(1); Clr_Overflow = 1'b0;
    wait_idle(2000);

    // reset during data bit 3 of the 2nd of 3 queued bytes
    f0 = m_frames;
    send(8'h5A); send(8'hC3); send(8'h96);
    for (int i = 0; i < 400 && !(m_frames == f0 + 2 && edge_n == fs + 17); i++) begin
      @(posedge Clk_In); #1;
    end
    check_val("rst_wait", m_frames, f0 + 2);
    @(negedge Clk_In); #1;
    Rst_N = 1'b0;
    #1;
    check_val("arst_tx",   Out_Tx, 1);
    check_val("arst_cnt",  Out_Fifo_Count, 0);
    check_val("arst_busy", Out_Busy, 0);
    @(posedge Clk_In); #1;
    Rst_N = 1'b1;
    idle(60);
    send(8'h3C);
    idle(50);

    // two stop bits on the second instance
    in_cmd_2 = 8'hFF; in_en_2 = 1'b1;
    @(posedge Clk_In); #1;
    e0 = edge_n;
    in_cmd_2 = 8'h00;
    @(posedge Clk_In); #1;
    in_en_2 = 1'b0;
    s1 = e0 + 1;
    s2 = s1 + FRAME2;
    ndone = 0;
    for (int i = 0; i < 2 * FRAME2 + 10; i++) begin
      @(negedge Clk_In);
      if (edge_n >= s1 && edge_n < s1 + FRAME2)      e2 = tx_at(s1, 8'hFF, edge_n);
      else if (edge_n >= s2 && edge_n < s2 + FRAME2) e2 = tx_at(s2, 8'h00, edge_n);
      else                                           e2 = 1'b1;
      check_val("tx2", tx_2, e2);
      if (done_2) begin
        ndone++;
        check_val("done2_pos", edge_n, (ndone == 1) ? s1 + FRAME2 - 1 : s2 + FRAME2 - 1);
      end
    end
    check_val("done2_cnt", ndone, 2);
    check_val("busy2", busy_2, 0);
    @(posedge Clk_In); #1;

    // random bursts with random gaps and clears
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        Clr_Overflow = ($urandom_range(0, 7) == 0);
        send(8'($urandom));
        Clr_Overflow = 1'b0;
        idle($urandom_range(0, 3));
      end
      idle($urandom_range(0, 60));
    end
    wait_idle(2000);
    idle(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
